// File: rtl/maze_player_ctrl.sv
// Maze game player controller: owns cell position, lives and freeze countdown, and sequences
// the sprite erase / obstacle lookup / move / redraw cycle on every frame tick.
module maze_player_ctrl #(
    parameter int unsigned X_W          = 8,
    parameter int unsigned Y_W          = 7,
    parameter int unsigned MAX_X        = 39,
    parameter int unsigned MAX_Y        = 29,
    parameter int unsigned START_X      = 0,
    parameter int unsigned START_Y      = 0,
    parameter int unsigned SPRITE       = 4,
    parameter int unsigned PX_W         = 10,
    parameter int unsigned PY_W         = 9,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned FREEZE_TICKS = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_tick,
    input  logic [2:0]     i_move,
    output logic           o_obs_req,
    output logic [X_W-1:0] o_obs_x,
    output logic [Y_W-1:0] o_obs_y,
    input  logic           i_obs_valid,
    input  logic [2:0]     i_obs_type,
    output logic           o_plot,
    output logic [PX_W-1:0] o_px,
    output logic [PY_W-1:0] o_py,
    output logic [1:0]     o_color,
    output logic [X_W-1:0] o_pos_x,
    output logic [Y_W-1:0] o_pos_y,
    output logic [3:0]     o_lives,
    output logic           o_won,
    output logic           o_game_over,
    output logic [3:0]     o_state_cur
);

    localparam int unsigned CW = (SPRITE > 1) ? $clog2(SPRITE) : 1;
    localparam int unsigned FW = $clog2(FREEZE_TICKS + 1);
    localparam logic [CW-1:0] LAST_PIX = CW'(SPRITE - 1);

    typedef enum logic [3:0] {
        StInit     = 4'd0,
        StWaitTick = 4'd1,
        StErase    = 4'd2,
        StLookup   = 4'd3,
        StWaitObs  = 4'd4,
        StDecide   = 4'd5,
        StMove     = 4'd6,
        StRestart  = 4'd7,
        StFrozen   = 4'd8,
        StDraw     = 4'd9,
        StWin      = 4'd10,
        StOver     = 4'd11
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CW-1:0]   r_col;
    logic [CW-1:0]   r_row;
    logic            r_swept;
    logic [2:0]      r_move;
    logic [2:0]      r_obs_type;
    logic [FW-1:0]   r_frz_cnt;
    logic [X_W-1:0]  r_pos_x;
    logic [Y_W-1:0]  r_pos_y;
    logic [3:0]      r_lives;
    logic            r_won;
    logic            r_game_over;

    logic            w_sweep;
    logic            w_last_pix;
    logic            w_tgt_ok;
    logic [X_W-1:0]  w_tgt_x;
    logic [Y_W-1:0]  w_tgt_y;
    logic [PX_W-1:0] w_px;
    logic [PY_W-1:0] w_py;

    // FROZEN and WIN paint their sprite once, then sit with plot low.
    always_comb begin
        w_sweep = 1'b0;
        unique case (r_state)
            StErase, StDraw:  w_sweep = 1'b1;
            StFrozen, StWin:  w_sweep = !r_swept;
            default:          w_sweep = 1'b0;
        endcase
    end

    assign w_last_pix = (r_col == LAST_PIX) && (r_row == LAST_PIX);

    // Target cell; pos is stable from LOOKUP through MOVE, so this doubles as the held obs_x/y.
    always_comb begin
        w_tgt_x  = r_pos_x;
        w_tgt_y  = r_pos_y;
        w_tgt_ok = 1'b0;
        case (r_move)
            3'd1: if (r_pos_x != '0) begin
                w_tgt_x  = r_pos_x - 1'b1;
                w_tgt_ok = 1'b1;
            end
            3'd2: if (r_pos_x != X_W'(MAX_X)) begin
                w_tgt_x  = r_pos_x + 1'b1;
                w_tgt_ok = 1'b1;
            end
            3'd3: if (r_pos_y != '0) begin
                w_tgt_y  = r_pos_y - 1'b1;
                w_tgt_ok = 1'b1;
            end
            3'd4: if (r_pos_y != Y_W'(MAX_Y)) begin
                w_tgt_y  = r_pos_y + 1'b1;
                w_tgt_ok = 1'b1;
            end
            default: w_tgt_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StInit:     w_state_d = StWaitTick;
            StWaitTick: if (i_tick) w_state_d = StErase;
            StErase:    if (w_last_pix) w_state_d = StLookup;
            StLookup:   w_state_d = w_tgt_ok ? StWaitObs : StDraw;
            StWaitObs:  if (i_obs_valid) w_state_d = StDecide;
            StDecide: begin
                case (r_obs_type)
                    3'd0, 3'd4: w_state_d = StMove;
                    3'd2:       w_state_d = StRestart;
                    3'd3:       w_state_d = StFrozen;
                    default:    w_state_d = StDraw;
                endcase
            end
            StMove:     w_state_d = (r_obs_type == 3'd4) ? StWin : StDraw;
            StRestart:  w_state_d = (r_lives == 4'd1) ? StOver : StDraw;
            StFrozen:   if (i_tick && r_frz_cnt == FW'(1)) w_state_d = StDraw;
            StDraw:     if (w_last_pix) w_state_d = StWaitTick;
            StWin:      w_state_d = StWin;
            StOver:     w_state_d = StOver;
            default:    w_state_d = StInit;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StInit;
            r_col       <= '0;
            r_row       <= '0;
            r_swept     <= 1'b0;
            r_move      <= '0;
            r_obs_type  <= '0;
            r_frz_cnt   <= '0;
            r_pos_x     <= X_W'(START_X);
            r_pos_y     <= Y_W'(START_Y);
            r_lives     <= 4'(LIVES);
            r_won       <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state <= w_state_d;

            if ((w_state_d != r_state) || !w_sweep) begin
                r_col <= '0;
                r_row <= '0;
            end else if (r_col == LAST_PIX) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end

            if (w_state_d != r_state) begin
                r_swept <= 1'b0;
            end else if (w_sweep && w_last_pix) begin
                r_swept <= 1'b1;
            end

            if (r_state == StErase && w_last_pix) begin
                r_move <= i_move;
            end

            if (r_state == StWaitObs && i_obs_valid) begin
                r_obs_type <= i_obs_type;
            end

            if (r_state == StDecide && r_obs_type == 3'd3) begin
                r_frz_cnt <= FW'(FREEZE_TICKS);
            end else if (r_state == StFrozen && i_tick && r_frz_cnt != '0) begin
                r_frz_cnt <= r_frz_cnt - 1'b1;
            end

            if (r_state == StMove) begin
                r_pos_x <= w_tgt_x;
                r_pos_y <= w_tgt_y;
                if (r_obs_type == 3'd4) begin
                    r_won <= 1'b1;
                end
            end

            if (r_state == StRestart) begin
                r_lives <= r_lives - 1'b1;
                if (r_lives == 4'd1) begin
                    r_game_over <= 1'b1;
                end else begin
                    r_pos_x <= X_W'(START_X);
                    r_pos_y <= Y_W'(START_Y);
                end
            end
        end
    end

    assign w_px = PX_W'(r_pos_x) * PX_W'(SPRITE) + PX_W'(r_col);
    assign w_py = PY_W'(r_pos_y) * PY_W'(SPRITE) + PY_W'(r_row);

    always_comb begin
        o_color = 2'd0;
        case (r_state)
            StFrozen: o_color = 2'd2;
            StDraw:   o_color = 2'd1;
            StWin:    o_color = 2'd3;
            default:  o_color = 2'd0;
        endcase
    end

    assign o_plot      = w_sweep;
    assign o_px        = w_sweep ? w_px : '0;
    assign o_py        = w_sweep ? w_py : '0;
    assign o_obs_req   = (r_state == StLookup) && w_tgt_ok;
    assign o_obs_x     = w_tgt_x;
    assign o_obs_y     = w_tgt_y;
    assign o_pos_x     = r_pos_x;
    assign o_pos_y     = r_pos_y;
    assign o_lives     = r_lives;
    assign o_won       = r_won;
    assign o_game_over = r_game_over;
    assign o_state_cur = r_state;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Scoreboard bench for maze_player_ctrl: expected pixels are queued as moves are issued and
// popped as the controller plots them; a responder task models the obstacle memory.
module tb_maze_player_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [2:0]  move;
    logic        obs_req;
    logic [7:0]  obs_x;
    logic [6:0]  obs_y;
    logic        obs_valid;
    logic [2:0]  obs_type;
    logic        plot;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [1:0]  color;
    logic [7:0]  pos_x;
    logic [6:0]  pos_y;
    logic [3:0]  lives;
    logic        won;
    logic        game_over;
    logic [3:0]  state_cur;

    always #5 clk = ~clk;

    maze_player_ctrl u_dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_tick      (tick),
        .i_move      (move),
        .o_obs_req   (obs_req),
        .o_obs_x     (obs_x),
        .o_obs_y     (obs_y),
        .i_obs_valid (obs_valid),
        .i_obs_type  (obs_type),
        .o_plot      (plot),
        .o_px        (px),
        .o_py        (py),
        .o_color     (color),
        .o_pos_x     (pos_x),
        .o_pos_y     (pos_y),
        .o_lives     (lives),
        .o_won       (won),
        .o_game_over (game_over),
        .o_state_cur (state_cur)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [31:0] exp_q[$];
    int          obs_delay = 1;
    logic [2:0]  obs_resp  = 3'd0;
    int          n_req     = 0;
    int          exp_tx    = 0;
    int          exp_ty    = 0;
    int          m_x, m_y, m_lives;
    bit          m_won, m_over;

    task automatic push_sweep(input int x, input int y, input int c);
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                exp_q.push_back({11'b0, 10'(x * 4 + col), 9'(y * 4 + row), 2'(c)});
            end
        end
    endtask

    // Pixel monitor
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (plot) begin
                if (exp_q.size() == 0) begin
                    check("extra_plot", 32'(plot), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {11'b0, px, py, color}, e);
                end
            end
        end
    end

    // Obstacle memory model
    initial begin : responder
        obs_valid = 1'b0;
        obs_type  = 3'd0;
        forever begin
            @(negedge clk);
            obs_valid = 1'b0;
            if (obs_req) begin
                n_req++;
                check("obs_x", 32'(obs_x), 32'(exp_tx));
                check("obs_y", 32'(obs_y), 32'(exp_ty));
                repeat (obs_delay) @(negedge clk);
                obs_valid = 1'b1;
                obs_type  = obs_resp;
            end
        end
    end

    task automatic send_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_state(input int st, input string tag);
        int k = 0;
        while (int'(state_cur) != st && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(state_cur), 32'(st));
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (14) @(negedge clk);
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_lives = 3; m_won = 0; m_over = 0;
        exp_q.delete();
    endtask

    task automatic play(input logic [2:0] mv, input logic [2:0] ty);
        int tx, tyy, req0;
        bit ok;
        move     = mv;
        obs_resp = ty;
        req0     = n_req;
        tx = m_x; tyy = m_y; ok = 0;
        if (m_won || m_over) begin
            send_tick();
            repeat (20) @(negedge clk);
        end else begin
            wait_state(1, "idle_before_tick");
            case (mv)
                3'd1: if (m_x != 0)  begin tx = m_x - 1; ok = 1; end
                3'd2: if (m_x != 39) begin tx = m_x + 1; ok = 1; end
                3'd3: if (m_y != 0)  begin tyy = m_y - 1; ok = 1; end
                3'd4: if (m_y != 29) begin tyy = m_y + 1; ok = 1; end
                default: ok = 0;
            endcase
            exp_tx = tx;
            exp_ty = tyy;
            push_sweep(m_x, m_y, 0);
            if (!ok) begin
                push_sweep(m_x, m_y, 1);
            end else begin
                case (ty)
                    3'd0: begin m_x = tx; m_y = tyy; push_sweep(m_x, m_y, 1); end
                    3'd4: begin m_x = tx; m_y = tyy; m_won = 1; push_sweep(m_x, m_y, 3); end
                    3'd2: begin
                        m_lives--;
                        if (m_lives == 0) m_over = 1;
                        else begin m_x = 0; m_y = 0; push_sweep(m_x, m_y, 1); end
                    end
                    3'd3: push_sweep(m_x, m_y, 2);
                    default: push_sweep(m_x, m_y, 1);
                endcase
            end
            send_tick();
            check("tick_latency_plot", 32'(plot), 32'd1);
            drain();
        end
        check("req_count", 32'(n_req - req0), 32'(ok));
        check("pos_x", 32'(pos_x), 32'(m_x));
        check("pos_y", 32'(pos_y), 32'(m_y));
        check("lives", 32'(lives), 32'(m_lives));
        check("won", 32'(won), 32'(m_won));
        check("game_over", 32'(game_over), 32'(m_over));
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        move  = 3'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_cur), 32'd0);
        check("rst_pos", {pos_x, 1'b0, pos_y}, 32'd0);
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_flags", {won, game_over, plot, obs_req}, 32'd0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_pix", {px, py}, 32'd0);
        reset = 1'b0;

        play(3'd2, 3'd0);  // right into empty cell
        play(3'd1, 3'd0);  // back to origin
        play(3'd1, 3'd0);  // off left edge
        play(3'd3, 3'd0);  // off top edge
        play(3'd0, 3'd0);
        play(3'd6, 3'd0);  // undefined move code
        play(3'd2, 3'd0);
        play(3'd2, 3'd1);  // wall
        play(3'd2, 3'd7);  // undefined type counts as wall

        play(3'd2, 3'd3);  // ice
        check("frozen_state", 32'(state_cur), 32'd8);
        for (int i = 0; i < 7; i++) begin
            send_tick();
            repeat (3) @(negedge clk);
            check("frozen_hold", 32'(state_cur), 32'd8);
        end
        push_sweep(m_x, m_y, 1);
        send_tick();
        drain();
        check("thaw_state", 32'(state_cur), 32'd1);
        check("thaw_pos_x", 32'(pos_x), 32'(m_x));

        obs_delay = 5;
        play(3'd4, 3'd0);  // slow lookup
        obs_delay = 1;

        play(3'd4, 3'd2);  // lava
        play(3'd4, 3'd2);
        play(3'd4, 3'd2);
        check("over_state", 32'(state_cur), 32'd11);
        play(3'd2, 3'd0);  // ignored once over
        check("over_plot", 32'(plot), 32'd0);

        // Reset partway through an erase sweep
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wait_state(1, "idle_after_reset");
        move = 3'd2;
        push_sweep(0, 0, 0);
        send_tick();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(state_cur), 32'd0);
        check("midrst_plot", 32'(plot), 32'd0);
        check("midrst_lives", 32'(lives), 32'd3);
        reset = 1'b0;
        model_reset();

        play(3'd2, 3'd4);  // goal
        check("win_state", 32'(state_cur), 32'd10);
        play(3'd4, 3'd0);
        play(3'd1, 3'd0);
        check("win_hold", 32'(state_cur), 32'd10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
